// File: rtl/bw_mult_pipe.sv
// ============================================================================
// bw_mult_pipe : 3-stage Baugh-Wooley multiplier, signed/unsigned per op
// Revision     : 1.0
// ============================================================================
`default_nettype none

module bw_mult_pipe #(
  parameter int WIDTH = 16,
  parameter int TAG_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic               in_signed,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_product,
  output logic               out_signed,
  output logic [TAG_W-1:0]   out_tag
);

  localparam int PW = 2 * WIDTH;
  localparam int HALF = WIDTH / 2;
  localparam logic [PW-1:0] COMP = (PW'(1) << WIDTH) | (PW'(1) << (PW - 1));

  logic en;

  logic             v1_q, v1_d;
  logic [WIDTH-1:0] a1_q, a1_d;
  logic [WIDTH-1:0] b1_q, b1_d;
  logic             s1_q, s1_d;
  logic [TAG_W-1:0] t1_q, t1_d;

  logic             v2_q, v2_d;
  logic [PW-1:0]    lo2_q, lo2_d;
  logic [PW-1:0]    hi2_q, hi2_d;
  logic             s2_q, s2_d;
  logic [TAG_W-1:0] t2_q, t2_d;

  logic             v3_q, v3_d;
  logic [PW-1:0]    prod3_q, prod3_d;
  logic             s3_q, s3_d;
  logic [TAG_W-1:0] t3_q, t3_d;

  logic [PW-1:0] pp_row [WIDTH];
  logic [PW-1:0] sum_lo;
  logic [PW-1:0] sum_hi;
  logic [PW-1:0] sum_fin;

  assign en = !v3_q || out_ready;

  // Signed mode complements the bits where exactly one index is the MSB.
  for (genvar j = 0; j < WIDTH; j++) begin : g_row
    logic [WIDTH-1:0] inv_mask;
    logic [WIDTH-1:0] row_bits;
    if (j == WIDTH - 1) begin : g_msb_row
      assign inv_mask = {1'b0, {(WIDTH-1){1'b1}}};
    end else begin : g_low_row
      assign inv_mask = {1'b1, {(WIDTH-1){1'b0}}};
    end
    assign row_bits  = (a1_q & {WIDTH{b1_q[j]}}) ^ (s1_q ? inv_mask : '0);
    assign pp_row[j] = PW'(row_bits) << j;
  end

  always_comb begin
    sum_lo = '0;
    sum_hi = '0;
    for (int j = 0; j < HALF; j++) begin
      sum_lo = sum_lo + pp_row[j];
    end
    for (int j = HALF; j < WIDTH; j++) begin
      sum_hi = sum_hi + pp_row[j];
    end
  end

  assign sum_fin = lo2_q + hi2_q + (s2_q ? COMP : '0);

  always_comb begin
    v1_d    = v1_q;
    a1_d    = a1_q;
    b1_d    = b1_q;
    s1_d    = s1_q;
    t1_d    = t1_q;
    v2_d    = v2_q;
    lo2_d   = lo2_q;
    hi2_d   = hi2_q;
    s2_d    = s2_q;
    t2_d    = t2_q;
    v3_d    = v3_q;
    prod3_d = prod3_q;
    s3_d    = s3_q;
    t3_d    = t3_q;
    if (en) begin
      v1_d    = in_valid;
      a1_d    = in_a;
      b1_d    = in_b;
      s1_d    = in_signed;
      t1_d    = in_tag;
      v2_d    = v1_q;
      lo2_d   = sum_lo;
      hi2_d   = sum_hi;
      s2_d    = s1_q;
      t2_d    = t1_q;
      v3_d    = v2_q;
      prod3_d = sum_fin;
      s3_d    = s2_q;
      t3_d    = t2_q;
    end
    // Flush wins over any handshake, including the one offered this cycle.
    if (flush) begin
      v1_d = 1'b0;
      v2_d = 1'b0;
      v3_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q    <= 1'b0;
      a1_q    <= '0;
      b1_q    <= '0;
      s1_q    <= 1'b0;
      t1_q    <= '0;
      v2_q    <= 1'b0;
      lo2_q   <= '0;
      hi2_q   <= '0;
      s2_q    <= 1'b0;
      t2_q    <= '0;
      v3_q    <= 1'b0;
      prod3_q <= '0;
      s3_q    <= 1'b0;
      t3_q    <= '0;
    end else begin
      v1_q    <= v1_d;
      a1_q    <= a1_d;
      b1_q    <= b1_d;
      s1_q    <= s1_d;
      t1_q    <= t1_d;
      v2_q    <= v2_d;
      lo2_q   <= lo2_d;
      hi2_q   <= hi2_d;
      s2_q    <= s2_d;
      t2_q    <= t2_d;
      v3_q    <= v3_d;
      prod3_q <= prod3_d;
      s3_q    <= s3_d;
      t3_q    <= t3_d;
    end
  end

  assign in_ready    = en;
  assign out_valid   = v3_q;
  assign out_product = prod3_q;
  assign out_signed  = s3_q;
  assign out_tag     = t3_q;

endmodule

`default_nettype wire

// File: tb/tb_bw_mult_pipe.sv
// ============================================================================
// tb_bw_mult_pipe : scoreboard bench for bw_mult_pipe (WIDTH=16, TAG_W=4)
// Revision        : 1.0
// ============================================================================
`default_nettype none

module tb_bw_mult_pipe;

  localparam int W  = 16;
  localparam int TW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_a = '0;
  logic [W-1:0]  in_b = '0;
  logic          in_signed = 1'b0;
  logic [TW-1:0] in_tag = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [2*W-1:0] out_product;
  logic          out_signed;
  logic [TW-1:0] out_tag;

  bw_mult_pipe #(.WIDTH(W), .TAG_W(TW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_signed(in_signed), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_product(out_product), .out_signed(out_signed), .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]   prod;
    logic          sgn;
    logic [TW-1:0] tag;
    int            issue;
  } exp_t;

  exp_t sb[$];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  bit chk_lat = 1'b0;
  bit last_hs = 1'b0;
  bit ready_low_seen = 1'b0;
  bit stall_prev = 1'b0;
  logic [31:0]   cur_exp = '0;
  logic [31:0]   held_prod = '0;
  logic          held_sgn = 1'b0;
  logic [TW-1:0] held_tag = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_prod(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic s);
    longint x, y;
    logic [63:0] p;
    x = s ? longint'($signed(a)) : longint'(a);
    y = s ? longint'($signed(b)) : longint'(b);
    p = x * y;
    return p[31:0];
  endfunction

  // One clock: sample at negedge, then return 1 time unit after the posedge.
  task automatic cycle();
    exp_t e;
    @(negedge clk);
    cyc++;
    check("in_ready_rule", in_ready, !out_valid || out_ready);
    if (!in_ready) ready_low_seen = 1'b1;
    if (out_valid && sb.size() == 0) check("spurious_valid", out_valid, 1'b0);
    if (out_valid && stall_prev) begin
      check("hold_product", out_product, held_prod);
      check("hold_signed", out_signed, held_sgn);
      check("hold_tag", out_tag, held_tag);
    end
    if (out_valid && out_ready && sb.size() != 0) begin
      e = sb.pop_front();
      check("product", out_product, e.prod);
      check("out_signed", out_signed, e.sgn);
      check("out_tag", out_tag, e.tag);
      if (chk_lat) check("latency", cyc - e.issue, 3);
    end
    stall_prev = out_valid && !out_ready;
    held_prod  = out_product;
    held_sgn   = out_signed;
    held_tag   = out_tag;
    last_hs = in_valid && in_ready;
    if (flush) begin
      sb.delete();
    end else if (last_hs && rst_n) begin
      e.prod  = cur_exp;
      e.sgn   = in_signed;
      e.tag   = in_tag;
      e.issue = cyc;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                       input logic [TW-1:0] t, input logic [31:0] e);
    in_a = a; in_b = b; in_signed = s; in_tag = t; cur_exp = e;
    in_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      cycle();
      if (last_hs) break;
    end
    if (!last_hs) check("issue_timeout", last_hs, 1'b1);
    in_valid = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    in_valid = 1'b0;
    while (sb.size() != 0 && n < budget) begin
      cycle();
      n++;
    end
    if (sb.size() != 0) check("drain_timeout", sb.size(), 0);
    sb.delete();
  endtask

  initial begin
    logic [W-1:0] bp_a [8];
    logic [W-1:0] bp_b [8];
    logic         bp_s [8];
    int k, start, issued;

    // Power-on reset, asserted between edges.
    #1 rst_n = 1'b0;
    #2;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_product", out_product, 32'h0);
    check("rst_out_tag", out_tag, 4'h0);
    check("rst_out_signed", out_signed, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Signed corners, back-to-back, fixed latency.
    out_ready = 1'b1;
    chk_lat = 1'b1;
    issue(16'h8000, 16'h8000, 1'b1, 4'd1, 32'h4000_0000);
    issue(16'h7FFF, 16'h8000, 1'b1, 4'd2, 32'hC000_8000);
    issue(16'hFFFF, 16'hFFFF, 1'b1, 4'd3, 32'h0000_0001);
    drain(20);

    // Same operands, mixed modes back-to-back.
    issue(16'hFFFF, 16'hFFFF, 1'b0, 4'd4, 32'hFFFE_0001);
    issue(16'hFFFF, 16'hFFFF, 1'b1, 4'd5, 32'h0000_0001);
    drain(20);
    chk_lat = 1'b0;

    // Backpressure: tags 0..7 with a 5-cycle out_ready stall mid-stream.
    for (int i = 0; i < 8; i++) begin
      bp_a[i] = W'($urandom);
      bp_b[i] = W'($urandom);
      bp_s[i] = 1'($urandom);
    end
    ready_low_seen = 1'b0;
    k = 0;
    start = cyc;
    for (int i = 0; i < 100 && k < 8; i++) begin
      out_ready = !((cyc - start) >= 4 && (cyc - start) < 9);
      in_valid  = 1'b1;
      in_a      = bp_a[k];
      in_b      = bp_b[k];
      in_signed = bp_s[k];
      in_tag    = k[TW-1:0];
      cur_exp   = ref_prod(bp_a[k], bp_b[k], bp_s[k]);
      cycle();
      if (last_hs) k++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    check("bp_all_issued", k, 8);
    check("bp_in_ready_dropped", ready_low_seen, 1'b1);
    drain(40);

    // Flush on the cycle of the third handshake drops all three.
    issue(16'd11, 16'd13, 1'b0, 4'd1, 32'd143);
    issue(16'd17, 16'd19, 1'b0, 4'd2, 32'd323);
    in_a = 16'd23; in_b = 16'd29; in_signed = 1'b0; in_tag = 4'd3; cur_exp = 32'd667;
    in_valid = 1'b1;
    flush = 1'b1;
    cycle();
    check("flush_cycle_in_ready", last_hs, 1'b1);
    flush = 1'b0;
    idle(6);
    chk_lat = 1'b1;
    issue(16'd5, 16'd7, 1'b0, 4'd9, 32'd35);
    drain(20);
    chk_lat = 1'b0;

    // Asynchronous reset with three operations in flight.
    issue(16'd100, 16'd200, 1'b0, 4'd1, 32'd20000);
    issue(16'hFFFE, 16'd3, 1'b1, 4'd2, 32'hFFFF_FFFA);
    issue(16'd7, 16'd9, 1'b0, 4'd3, 32'd63);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_out_product", out_product, 32'h0);
    check("midrst_out_tag", out_tag, 4'h0);
    sb.delete();
    stall_prev = 1'b0;
    idle(2);
    rst_n = 1'b1;
    idle(6);
    chk_lat = 1'b1;
    issue(16'd3, 16'hFFFD, 1'b1, 4'd6, 32'hFFFF_FFF7);
    drain(20);
    chk_lat = 1'b0;

    // Random regression: operands, modes, valid and out_ready patterns.
    issued = 0;
    for (int i = 0; i < 60000 && issued < 10000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      in_a      = W'($urandom);
      in_b      = W'($urandom);
      in_signed = 1'($urandom);
      in_tag    = TW'($urandom);
      cur_exp   = ref_prod(in_a, in_b, in_signed);
      cycle();
      if (last_hs) issued++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    check("rand_all_issued", issued, 10000);
    drain(40);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/bw_mult_pipe.md
Name: bw_mult_pipe

Overview:
- Parametrised, pipelined Baugh-Wooley multiplier. Successor to the team's fixed 16x16 combinational signed multiplier.
- Adds configurable operand width, per-transaction signed/unsigned mode, a 3-stage pipeline with valid/ready backpressure, a synchronous flush, and a pass-through tag.
- Sits between the datapath operand registers and the accumulator/MAC stage.

Parameters:
- WIDTH, 16, operand width in bits; even, 4..32.
- TAG_W, 4, width of the sideband tag carried alongside each operation.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous clear of all in-flight operations.
- in_valid  input  1  operand pair present.
- in_ready  output  1  block accepts the operand pair this cycle.
- in_a  input  WIDTH  multiplicand.
- in_b  input  WIDTH  multiplier.
- in_signed  input  1  1 = two's-complement operands, 0 = unsigned.
- in_tag  input  TAG_W  user tag.
- out_valid  output  1  result present.
- out_ready  input  1  downstream accepts the result.
- out_product  output  2*WIDTH  product (signed or unsigned per mode).
- out_signed  output  1  mode of the result.
- out_tag  output  TAG_W  tag of the result.

Behaviour:
- Reset (rst_n low, asynchronous):
  - All stage valid bits clear, so out_valid=0.
  - out_product=0, out_tag=0, out_signed=0; all internal data registers cleared.
- Pipeline enable: en = !out_valid || out_ready. in_ready = en (combinational).
- When en=0, every stage holds; a bubble is not collapsed while stalled.
- Stage 1 (S1), on in_valid && in_ready: register a, b, signed, tag.
- Stage 2 (S2), partial product generation:
  - pp[i][j] = a[i] & b[j].
  - In signed mode, invert pp[i][j] when exactly one of i, j equals WIDTH-1.
  - Reduce rows 0..WIDTH/2-1 and rows WIDTH/2..WIDTH-1 into two registered 2*WIDTH partial sums.
- Stage 3 (S3): final add of the two partial sums.
  - Signed mode adds compensation constant 2^WIDTH + 2^(2*WIDTH-1).
  - Unsigned mode adds 0.
  - All arithmetic is modulo 2^(2*WIDTH).
- Latency: exactly 3 cycles from input handshake to out_valid when unstalled. Throughput is 1 operation per cycle.
- Output handshake: out_product, out_tag and out_signed hold stable while out_valid && !out_ready.
- Flush:
  - Clears all stage valid bits next edge; data registers may keep stale values.
  - An input presented in the same cycle as flush is dropped, even if in_ready=1.
  - flush has priority over the handshake.
- Reset mid-operation: all in-flight results are lost and no spurious out_valid is produced after release.
- Ordering: results emerge in input order; tags are never reordered or duplicated.
- A result is consumed exactly once, on the cycle where out_valid && out_ready.
- Mode is per transaction: mixed signed/unsigned back-to-back operations must not interfere.

Test Plan (all cases WIDTH=16):
- Signed corners, out_ready=1:
  - (-32768)x(-32768) -> 0x40000000.
  - 32767x(-32768) -> 0xC0008000.
  - (-1)x(-1) -> 0x00000001.
  - Each appears exactly 3 cycles after its input handshake.
- Unsigned corners:
  - 0xFFFFx0xFFFF, in_signed=0 -> 0xFFFE0001.
  - Same operands with in_signed=1 -> 0x00000001.
  - Issued back-to-back, results in order with matching out_signed.
- Backpressure:
  - Stream tags 0..7 with random operands; hold out_ready=0 for 5 cycles mid-stream.
  - in_ready drops, out_* stay stable, no loss or duplication.
  - Results match the reference product model, tags 0..7 in order.
- Flush:
  - Issue 3 operations, assert flush for 1 cycle on the cycle of the 3rd handshake.
  - No out_valid for any of them; the next operation, 5x7, returns 35 after 3 cycles.
- Async reset mid-stream:
  - Pull rst_n low between edges with 3 operations in flight.
  - out_valid and out_product go to 0 immediately; after release, nothing emerges until new input.
- Random regression: 10k random operands, modes and out_ready patterns, compared against a 32-bit golden model (signed or unsigned per mode).
